// File: rtl/keypad_matrix_entry_pkg.sv
// Shared key codes, FSM state type and key classification helper for the
// keypad matrix loader.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_DONE  = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    ENTRY,
    FULL,
    DONE
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_matrix_entry_key_event_detect.sv
// Rising-edge detector on key_pressed: one key_event per press, with the
// key code passed through in the same cycle.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_key_code,
  input  logic       i_key_pressed,
  output logic       o_key_event,
  output logic [3:0] o_key_code
);

  logic r_prev;
  logic r_hold;

  // r_hold remembers a key that was already down at the last reset edge so
  // it cannot masquerade as a fresh press once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_hold <= i_key_pressed;
    end else begin
      r_prev <= i_key_pressed;
      r_hold <= r_hold & i_key_pressed;
    end
  end

  assign o_key_event = i_key_pressed & ~r_prev & ~r_hold;
  assign o_key_code  = i_key_code;

endmodule

// File: rtl/keypad_matrix_entry.sv
// Keypad-to-matrix loader: builds signed decimal entries from key events,
// stores them row-major and hands the full matrix over with valid/ack.
module keypad_matrix_entry #(
  parameter int ELEM_WIDTH = 12,
  parameter int NUM_ROWS   = 3,
  parameter int NUM_COLS   = 2,
  parameter int MAX_DIGITS = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [3:0]                               key_code,
  input  logic                                     key_pressed,
  input  logic                                     matrix_ack,
  output logic [NUM_ROWS*NUM_COLS*ELEM_WIDTH-1:0]  matrix_out,
  output logic                                     matrix_valid,
  output logic [ELEM_WIDTH-1:0]                    entry_value,
  output logic [4*MAX_DIGITS-1:0]                  entry_digits,
  output logic                                     entry_neg,
  output logic [$clog2(NUM_ROWS)-1:0]              row_idx,
  output logic [$clog2(NUM_COLS)-1:0]              col_idx,
  output logic                                     elem_written,
  output logic                                     overflow_err
);

  import keypad_entry_pkg::*;

  localparam int RW  = $clog2(NUM_ROWS);
  localparam int CW  = $clog2(NUM_COLS);
  localparam int NE  = NUM_ROWS * NUM_COLS;
  localparam int AW  = (NE > 1) ? $clog2(NE) : 1;
  localparam int MW  = ELEM_WIDTH - 1;
  localparam int XW  = ELEM_WIDTH + 4;
  localparam int DW  = 4 * MAX_DIGITS;
  localparam int NDW = $clog2(MAX_DIGITS + 1);

  localparam logic [XW-1:0] MAG_MAX  = XW'((1 << (ELEM_WIDTH - 1)) - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  entry_state_t           r_state;
  entry_state_t           w_state_nxt;
  logic [MW-1:0]          r_mag;
  logic [DW-1:0]          r_digits;
  logic [NDW-1:0]         r_ndigits;
  logic                   r_neg;
  logic [RW-1:0]          r_row;
  logic [CW-1:0]          r_col;
  logic [NE*ELEM_WIDTH-1:0] r_matrix;
  logic                   r_elem_written;
  logic                   r_ovf;

  logic                   w_event;
  logic [3:0]             w_code;
  logic [XW-1:0]          w_mag_next;
  logic                   w_digit_ok;
  logic                   w_last;
  logic [AW-1:0]          w_wr_addr;
  logic [NE-1:0]          w_wr_en;
  logic [ELEM_WIDTH-1:0]  w_value;

  logic w_do_digit, w_do_reject, w_do_sign, w_do_bs, w_do_clr, w_do_enter;
  logic w_idx_clr, w_ack_clr;

  key_event_detect u_key_event_detect (
    .clk           (clk),
    .rst           (rst),
    .i_key_code    (key_code),
    .i_key_pressed (key_pressed),
    .o_key_event   (w_event),
    .o_key_code    (w_code)
  );

  assign w_mag_next = ({{(XW-MW){1'b0}}, r_mag} * XW'(10)) + {{(XW-4){1'b0}}, w_code};
  assign w_digit_ok = (r_ndigits < NDW'(MAX_DIGITS)) && (w_mag_next <= MAG_MAX);
  assign w_last     = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_wr_addr  = (AW'(r_row) * AW'(NUM_COLS)) + AW'(r_col);
  assign w_value    = r_neg ? -{1'b0, r_mag} : {1'b0, r_mag};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ENTRY;
    else     r_state <= w_state_nxt;
  end

  // Next-state and action decode from the current key event.
  always_comb begin
    w_state_nxt = r_state;
    w_do_digit  = 1'b0;
    w_do_reject = 1'b0;
    w_do_sign   = 1'b0;
    w_do_bs     = 1'b0;
    w_do_clr    = 1'b0;
    w_do_enter  = 1'b0;
    w_idx_clr   = 1'b0;
    w_ack_clr   = 1'b0;
    case (r_state)
      ENTRY: begin
        if (w_event) begin
          if (is_digit(w_code)) begin
            w_do_digit  = w_digit_ok;
            w_do_reject = ~w_digit_ok;
          end else begin
            case (w_code)
              KEY_SIGN:  w_do_sign = 1'b1;
              KEY_BS:    w_do_bs   = 1'b1;
              KEY_CLR:   w_do_clr  = 1'b1;
              KEY_ENTER: begin
                w_do_enter = 1'b1;
                if (w_last) w_state_nxt = FULL;
              end
              default: ;
            endcase
          end
        end
      end
      FULL: begin
        if (w_event) begin
          if (w_code == KEY_DONE) begin
            w_state_nxt = DONE;
          end else if (w_code == KEY_CLR) begin
            w_state_nxt = ENTRY;
            w_idx_clr   = 1'b1;
          end
        end
      end
      DONE: begin
        if (matrix_ack) begin
          w_state_nxt = ENTRY;
          w_ack_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ENTRY;
    endcase
  end

  // Entry in progress: magnitude, BCD digits, sign and overflow flag.
  always_ff @(posedge clk) begin
    if (rst || w_do_clr || w_do_enter) begin
      r_mag     <= '0;
      r_digits  <= '0;
      r_ndigits <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_do_digit) begin
      r_mag     <= w_mag_next[MW-1:0];
      r_digits  <= DW'({r_digits, w_code});
      r_ndigits <= r_ndigits + NDW'(1);
    end else if (w_do_reject) begin
      r_ovf     <= 1'b1;
    end else if (w_do_sign) begin
      r_neg     <= ~r_neg;
    end else if (w_do_bs && (r_ndigits != '0)) begin
      r_mag     <= r_mag / MW'(10);
      r_digits  <= r_digits >> 4;
      r_ndigits <= r_ndigits - NDW'(1);
    end
  end

  // Row/column of the next element to be written.
  always_ff @(posedge clk) begin
    if (rst || w_idx_clr || w_ack_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_do_enter) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // One-hot write enable decoded from the flat element address.
  always_comb begin
    w_wr_en = '0;
    for (int unsigned e = 0; e < NE; e++) begin
      w_wr_en[e] = w_do_enter && (w_wr_addr == AW'(e));
    end
  end

  // Element storage and the commit pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_matrix       <= '0;
      r_elem_written <= 1'b0;
    end else begin
      r_elem_written <= w_do_enter;
      if (w_ack_clr) begin
        r_matrix <= '0;
      end else begin
        for (int unsigned e = 0; e < NE; e++) begin
          if (w_wr_en[e]) r_matrix[e*ELEM_WIDTH +: ELEM_WIDTH] <= w_value;
        end
      end
    end
  end

  assign matrix_out   = r_matrix;
  assign matrix_valid = (r_state == DONE);
  assign entry_value  = w_value;
  assign entry_digits = r_digits;
  assign entry_neg    = r_neg;
  assign row_idx      = r_row;
  assign col_idx      = r_col;
  assign elem_written = r_elem_written;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_keypad_matrix_entry.sv
// Scoreboarded bench for keypad_matrix_entry: expected element writes and
// expected matrices are queued by the stimulus and checked by a monitor.
module tb_keypad_matrix_entry;

  import keypad_entry_pkg::*;

  localparam int EW = 12;
  localparam int NE = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, key_pressed, matrix_ack;
  logic [3:0]     key_code;
  logic [NE*EW-1:0] matrix_out;
  logic           matrix_valid;
  logic [EW-1:0]  entry_value;
  logic [11:0]    entry_digits;
  logic           entry_neg;
  logic [1:0]     row_idx;
  logic [0:0]     col_idx;
  logic           elem_written, overflow_err;

  logic           s_key_pressed, s_matrix_ack;
  logic [3:0]     s_key_code;
  logic [47:0]    s_matrix_out;
  logic           s_matrix_valid;
  logic [7:0]     s_entry_value;
  logic [11:0]    s_entry_digits;
  logic           s_entry_neg;
  logic [1:0]     s_row_idx;
  logic [0:0]     s_col_idx;
  logic           s_elem_written, s_overflow_err;

  keypad_matrix_entry u_dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
    .matrix_ack(matrix_ack), .matrix_out(matrix_out), .matrix_valid(matrix_valid),
    .entry_value(entry_value), .entry_digits(entry_digits), .entry_neg(entry_neg),
    .row_idx(row_idx), .col_idx(col_idx), .elem_written(elem_written),
    .overflow_err(overflow_err)
  );

  keypad_matrix_entry #(.ELEM_WIDTH(8), .NUM_ROWS(3), .NUM_COLS(2), .MAX_DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .key_code(s_key_code), .key_pressed(s_key_pressed),
    .matrix_ack(s_matrix_ack), .matrix_out(s_matrix_out), .matrix_valid(s_matrix_valid),
    .entry_value(s_entry_value), .entry_digits(s_entry_digits), .entry_neg(s_entry_neg),
    .row_idx(s_row_idx), .col_idx(s_col_idx), .elem_written(s_elem_written),
    .overflow_err(s_overflow_err)
  );

  typedef struct {
    int            idx;
    logic [EW-1:0] val;
  } wr_t;

  wr_t              wr_q[$];
  logic [NE*EW-1:0] mat_q[$];
  wr_t              mon_w;
  logic [NE*EW-1:0] mon_m;
  logic             prev_valid = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every commit pulse and every rising matrix_valid consumes one
  // expected entry from the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && elem_written) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_elem_written: got pulse expected none");
      end else begin
        mon_w = wr_q.pop_front();
        check("elem_value", matrix_out[mon_w.idx*EW +: EW], mon_w.val);
      end
    end
    if (!rst && matrix_valid && !prev_valid) begin
      if (mat_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_matrix_valid: got rise expected none");
      end else begin
        mon_m = mat_q.pop_front();
        check("matrix_content", matrix_out, mon_m);
      end
    end
    prev_valid = matrix_valid;
  end

  task automatic press(input logic [3:0] k);
    key_code = k;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic press8(input logic [3:0] k);
    s_key_code = k;
    s_key_pressed = 1'b1;
    @(negedge clk);
    s_key_pressed = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; key_pressed = 1'b1; key_code = 4'd7; matrix_ack = 1'b0;
    s_key_pressed = 1'b0; s_key_code = 4'd0; s_matrix_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // reset state, key 7 held through reset release
    check("rst_value_held_key", entry_value, 0);
    check("rst_digits", entry_digits, 0);
    check("rst_neg", entry_neg, 0);
    check("rst_row", row_idx, 0);
    check("rst_col", col_idx, 0);
    check("rst_valid", matrix_valid, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_matrix", matrix_out, 0);
    key_pressed = 1'b0;
    @(negedge clk);

    // 1,2,3,E -> 123 at (0,0)
    press(4'd1); press(4'd2); press(4'd3);
    check("val_123", entry_value, 12'd123);
    check("digits_123", entry_digits, 12'h123);
    wr_q.push_back('{0, 12'd123});
    press(KEY_ENTER);
    check("col_after_e1", col_idx, 1);
    check("row_after_e1", row_idx, 0);
    check("ovf_after_e1", overflow_err, 0);
    check("val_cleared_e1", entry_value, 0);
    check("pulse_gone_e1", elem_written, 0);

    // A,4,5,B,E -> -4 at (0,1)
    press(KEY_SIGN); press(4'd4); press(4'd5);
    check("digits_45", entry_digits, 12'h045);
    press(KEY_BS);
    check("digits_bs", entry_digits, 12'h004);
    check("neg_set", entry_neg, 1);
    check("val_m4", entry_value, 12'hFFC);
    wr_q.push_back('{1, 12'hFFC});
    press(KEY_ENTER);
    check("digits_after_e2", entry_digits, 0);
    check("neg_after_e2", entry_neg, 0);
    check("row_after_e2", row_idx, 1);
    check("col_after_e2", col_idx, 0);

    // third element, then D in ENTRY is ignored
    press(4'd3);
    wr_q.push_back('{2, 12'd3});
    press(KEY_ENTER);
    press(KEY_DONE);
    check("d_in_entry_valid", matrix_valid, 0);
    press(4'd5);
    check("d_in_entry_still_entry", entry_value, 12'd5);
    check("d_in_entry_row", row_idx, 1);
    check("d_in_entry_col", col_idx, 1);

    // rst pulse mid-entry
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_value", entry_value, 0);
    check("midrst_digits", entry_digits, 0);
    check("midrst_row", row_idx, 0);
    check("midrst_col", col_idx, 0);
    check("midrst_matrix", matrix_out, 0);
    check("midrst_written", elem_written, 0);
    check("midrst_valid", matrix_valid, 0);
    @(negedge clk);

    // six elements 1..6 fill the matrix
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] kc;
      kc = 4'(k);
      press(kc);
      wr_q.push_back('{k - 1, EW'(k)});
      press(KEY_ENTER);
    end
    check("full_row", row_idx, 0);
    check("full_col", col_idx, 0);
    check("full_valid", matrix_valid, 0);
    press(4'd9);
    check("full_ignores_digit", entry_value, 0);

    mat_q.push_back({12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});
    key_code = KEY_DONE;
    key_pressed = 1'b1;
    check("valid_before_d", matrix_valid, 0);
    @(negedge clk);
    check("valid_after_d", matrix_valid, 1);
    key_pressed = 1'b0;
    @(negedge clk);
    check("valid_held", matrix_valid, 1);

    // ack and digit in the same cycle: ack wins, digit dropped
    key_code = 4'd8;
    key_pressed = 1'b1;
    matrix_ack = 1'b1;
    @(negedge clk);
    matrix_ack = 1'b0;
    key_pressed = 1'b0;
    check("ack_valid_low", matrix_valid, 0);
    check("ack_matrix_zero", matrix_out, 0);
    check("ack_digit_dropped", entry_value, 0);
    @(negedge clk);
    press(4'd4);
    check("entry_after_ack", entry_value, 12'd4);
    press(KEY_CLR);
    check("clr_value", entry_value, 0);

    // key held 20 cycles -> one digit
    key_code = 4'd7;
    key_pressed = 1'b1;
    repeat (20) @(negedge clk);
    check("held_value", entry_value, 12'd7);
    check("held_digits", entry_digits, 12'h007);
    key_pressed = 1'b0;
    @(negedge clk);

    // digit-count limit
    press(4'd9); press(4'd9);
    check("val_799", entry_value, 12'd799);
    check("ovf_before", overflow_err, 0);
    press(4'd9);
    check("val_799_kept", entry_value, 12'd799);
    check("ovf_digits", overflow_err, 1);
    press(KEY_BS);
    check("bs_79", entry_value, 12'd79);
    check("ovf_sticky", overflow_err, 1);
    press(KEY_CLR);
    check("clr_ovf", overflow_err, 0);
    check("clr_digits", entry_digits, 0);
    press(KEY_BS);
    check("bs_empty_value", entry_value, 0);
    check("bs_empty_digits", entry_digits, 0);

    // "-0" stores 0, double sign toggle restores positive
    press(KEY_SIGN);
    check("neg_zero_value", entry_value, 0);
    wr_q.push_back('{0, 12'd0});
    press(KEY_ENTER);
    press(KEY_SIGN); press(4'd1); press(4'd2); press(KEY_SIGN);
    wr_q.push_back('{1, 12'd12});
    press(KEY_ENTER);

    // magnitude limit on the 8-bit instance
    press8(4'd1); press8(4'd2); press8(4'd7);
    check("w8_val_127", s_entry_value, 8'd127);
    check("w8_ovf_clear", s_overflow_err, 0);
    press8(4'd8);
    check("w8_val_kept", s_entry_value, 8'd127);
    check("w8_ovf_set", s_overflow_err, 1);
    check("w8_digits", s_entry_digits, 12'h127);

    repeat (3) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 0);
    check("mat_q_drained", mat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
